// File: rtl/adder_tree_pkg.sv
// Shared width helpers for the adder tree and its sibling utilities.
//
// The tree's levels all live on one flat bus. Level k has (N >> k)
// lanes, and each lane is k+1 bits wide. level_offset() gives the
// position of level k on that bus.
package adder_tree_pkg;

   // Width of one partial sum at tree level k (level 0 is the raw input bit).
   function automatic int sum_width(input int level);
      return level + 1;
   endfunction

   // Accumulator width: must hold a full window of all-ones vectors.
   function automatic int acc_width(input int num_inputs, input int window);
      return $clog2(num_inputs * window + 1);
   endfunction

   // Total bits occupied by one tree level.
   function automatic int level_bits(input int num_inputs, input int level);
      return (num_inputs >> level) * sum_width(level);
   endfunction

   // Bit offset of a tree level on the flattened tree bus.
   function automatic int level_offset(input int num_inputs, input int level);
      int off;
      off = 0;
      for (int j = 0; j < level; j++) begin
         off += level_bits(num_inputs, j);
      end
      return off;
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pair-add level of the population-count tree.
//
// Ports:
//   CLK       rising-edge clock
//   nRST      asynchronous active-low reset
//   in_data   IN_COUNT lanes of IN_W bits, packed with lane 0 in the LSBs
//   in_valid  in_data carries a vector this cycle
//   out_data  IN_COUNT/2 lanes of IN_W+1 bits (sum of each adjacent pair)
//   out_valid in_valid delayed by one cycle
module adder_tree_level #(
   parameter int IN_COUNT = 8,
   parameter int IN_W     = 1
) (
   input  logic                                 CLK,
   input  logic                                 nRST,
   input  logic [IN_COUNT*IN_W-1:0]             in_data,
   input  logic                                 in_valid,
   output logic [(IN_COUNT/2)*(IN_W+1)-1:0]     out_data,
   output logic                                 out_valid
);

   localparam int OUT_COUNT = IN_COUNT / 2;
   localparam int OUT_W     = IN_W + 1;

   // The valid bit always advances. The data registers load only on a
   // valid vector. Because they hold otherwise, the final level keeps
   // its last sum visible while no new vector is arriving.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < OUT_COUNT; i++) begin
               out_data[i*OUT_W +: OUT_W] <= OUT_W'(in_data[(2*i)*IN_W +: IN_W])
                                           + OUT_W'(in_data[(2*i+1)*IN_W +: IN_W]);
            end
         end
      end
   end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined population counter with windowed accumulation.
//
// The block counts the ones in each valid input vector through a
// registered pair-add tree, with LEVELS cycles of latency. It then sums
// WINDOW consecutive counts into acc.
//
// Ports:
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   inputs     NUM_INPUTS one-bit lanes to count
//   in_valid   inputs is valid this cycle
//   clear      synchronous restart of the current window
//   sum        popcount of the most recent valid vector
//   sum_valid  sum is new this cycle
//   acc        total of the last completed window
//   acc_valid  one-cycle pulse when acc updates
module adder_tree_pipe
   import adder_tree_pkg::*;
#(
   parameter int NUM_INPUTS = 8,
   parameter int WINDOW     = 16,
   localparam int LEVELS    = $clog2(NUM_INPUTS),
   localparam int SW        = sum_width(LEVELS),
   localparam int AW        = acc_width(NUM_INPUTS, WINDOW)
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [NUM_INPUTS-1:0] inputs,
   input  logic                  in_valid,
   input  logic                  clear,
   output logic [SW-1:0]         sum,
   output logic                  sum_valid,
   output logic [AW-1:0]         acc,
   output logic                  acc_valid
);

   localparam int TREE_BITS = level_offset(NUM_INPUTS, LEVELS + 1);
   localparam int SUM_OFF   = level_offset(NUM_INPUTS, LEVELS);
   localparam int CW        = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WINDOW - 1);

   // Every level's lanes sit on one flat bus, and each instance drives
   // its own slice. Level 0 is the raw input vector.
   logic [TREE_BITS-1:0] tree_bus;
   logic [LEVELS:0]      tree_valid;

   logic [AW-1:0] running;
   logic [CW-1:0] window_count;

   assign tree_bus[NUM_INPUTS-1:0] = inputs;
   assign tree_valid[0]            = in_valid;

   for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      localparam int IN_OFF   = level_offset(NUM_INPUTS, k - 1);
      localparam int IN_BITS  = level_bits(NUM_INPUTS, k - 1);
      localparam int OUT_OFF  = level_offset(NUM_INPUTS, k);
      localparam int OUT_BITS = level_bits(NUM_INPUTS, k);

      adder_tree_level #(
         .IN_COUNT (NUM_INPUTS >> (k - 1)),
         .IN_W     (k)
      ) u_level (
         .CLK       (CLK),
         .nRST      (nRST),
         .in_data   (tree_bus[IN_OFF +: IN_BITS]),
         .in_valid  (tree_valid[k-1]),
         .out_data  (tree_bus[OUT_OFF +: OUT_BITS]),
         .out_valid (tree_valid[k])
      );
   end

   // The last tree level is a single register, so it serves directly as
   // the registered sum output.
   assign sum       = tree_bus[SUM_OFF +: SW];
   assign sum_valid = tree_valid[LEVELS];

   // This block sums each window of counts. On the window's final sample,
   // it publishes running+sum straight into acc so that the window does
   // not cost an extra cycle. clear wins over a coincident sample, which
   // is dropped.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         running      <= '0;
         window_count <= '0;
         acc          <= '0;
         acc_valid    <= 1'b0;
      end else begin
         acc_valid <= 1'b0;
         if (clear) begin
            running      <= '0;
            window_count <= '0;
         end else if (sum_valid) begin
            if (window_count == LAST_COUNT) begin
               acc          <= running + AW'(sum);
               acc_valid    <= 1'b1;
               running      <= '0;
               window_count <= '0;
            end else begin
               running      <= running + AW'(sum);
               window_count <= window_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed self-checking bench for adder_tree_pipe.
//
// The main instance uses 8 inputs with a window of 4. A second instance
// uses 2 inputs with a window of 1 to cover the degenerate window.
// Expected values are worked out by hand for each step.
module tb_adder_tree_pipe;

   logic       CLK;
   logic       nRST;
   logic [7:0] inputs;
   logic       in_valid;
   logic       clear;
   logic [3:0] sum;
   logic       sum_valid;
   logic [5:0] acc;
   logic       acc_valid;

   logic [1:0] inputs2;
   logic       in_valid2;
   logic       clear2;
   logic [1:0] sum2;
   logic       sum_valid2;
   logic [1:0] acc2;
   logic       acc_valid2;

   int checks;
   int errors;

   adder_tree_pipe #(
      .NUM_INPUTS (8),
      .WINDOW     (4)
   ) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .inputs    (inputs),
      .in_valid  (in_valid),
      .clear     (clear),
      .sum       (sum),
      .sum_valid (sum_valid),
      .acc       (acc),
      .acc_valid (acc_valid)
   );

   adder_tree_pipe #(
      .NUM_INPUTS (2),
      .WINDOW     (1)
   ) dut_w1 (
      .CLK       (CLK),
      .nRST      (nRST),
      .inputs    (inputs2),
      .in_valid  (in_valid2),
      .clear     (clear2),
      .sum       (sum2),
      .sum_valid (sum_valid2),
      .acc       (acc2),
      .acc_valid (acc_valid2)
   );

   // Free-running 10-time-unit clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Single point of comparison: counts every check, reports mismatches.
   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of stimulus, then check the state that follows the
   // clock edge.
   task automatic apply_stimulus(input string tag, input logic [7:0] vec,
                                 input logic v, input logic clr,
                                 input int exp_sum, input int exp_sv,
                                 input int exp_acc, input int exp_av);
      inputs   = vec;
      in_valid = v;
      clear    = clr;
      @(posedge CLK);
      #1;
      check_output({tag, " sum"},       32'(sum),       32'(exp_sum));
      check_output({tag, " sum_valid"}, 32'(sum_valid), 32'(exp_sv));
      check_output({tag, " acc"},       32'(acc),       32'(exp_acc));
      check_output({tag, " acc_valid"}, 32'(acc_valid), 32'(exp_av));
   endtask

   // Reset that is asserted for a full cycle and released just after an
   // edge.
   task automatic apply_reset();
      nRST      = 1'b0;
      inputs    = 8'h00;
      in_valid  = 1'b0;
      clear     = 1'b0;
      in_valid2 = 1'b0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      nRST      = 1'b0;
      inputs    = 8'hFF;
      in_valid  = 1'b1;
      clear     = 1'b0;
      inputs2   = 2'b00;
      in_valid2 = 1'b0;
      clear2    = 1'b0;

      $display("[TB] reset held with active inputs");
      apply_stimulus("rst.c0", 8'hFF, 1, 0, 0, 0, 0, 0);
      apply_stimulus("rst.c1", 8'hFF, 1, 0, 0, 0, 0, 0);
      apply_stimulus("rst.c2", 8'hFF, 1, 0, 0, 0, 0, 0);
      in_valid = 1'b0;
      inputs   = 8'h00;
      nRST     = 1'b1;

      $display("[TB] single vector latency");
      apply_stimulus("lat.s0", 8'hFF, 1, 0, 0, 0, 0, 0);
      apply_stimulus("lat.s1", 8'h00, 0, 0, 0, 0, 0, 0);
      apply_stimulus("lat.s2", 8'h00, 0, 0, 8, 1, 0, 0);
      apply_stimulus("lat.s3", 8'h00, 0, 0, 8, 0, 0, 0);

      $display("[TB] back-to-back window");
      apply_reset();
      apply_stimulus("b2b.s0", 8'h01, 1, 0, 0, 0, 0, 0);
      apply_stimulus("b2b.s1", 8'h03, 1, 0, 0, 0, 0, 0);
      apply_stimulus("b2b.s2", 8'h07, 1, 0, 1, 1, 0, 0);
      apply_stimulus("b2b.s3", 8'hFF, 1, 0, 2, 1, 0, 0);
      apply_stimulus("b2b.s4", 8'h00, 0, 0, 3, 1, 0, 0);
      apply_stimulus("b2b.s5", 8'h00, 0, 0, 8, 1, 0, 0);
      apply_stimulus("b2b.s6", 8'h00, 0, 0, 8, 0, 14, 1);
      apply_stimulus("b2b.s7", 8'h00, 0, 0, 8, 0, 14, 0);

      $display("[TB] gapped window");
      apply_reset();
      apply_stimulus("gap.s0",  8'h01, 1, 0, 0, 0, 0, 0);
      apply_stimulus("gap.s1",  8'h00, 0, 0, 0, 0, 0, 0);
      apply_stimulus("gap.s2",  8'h00, 0, 0, 1, 1, 0, 0);
      apply_stimulus("gap.s3",  8'h03, 1, 0, 1, 0, 0, 0);
      apply_stimulus("gap.s4",  8'h00, 0, 0, 1, 0, 0, 0);
      apply_stimulus("gap.s5",  8'h00, 0, 0, 2, 1, 0, 0);
      apply_stimulus("gap.s6",  8'h07, 1, 0, 2, 0, 0, 0);
      apply_stimulus("gap.s7",  8'h00, 0, 0, 2, 0, 0, 0);
      apply_stimulus("gap.s8",  8'h00, 0, 0, 3, 1, 0, 0);
      apply_stimulus("gap.s9",  8'hFF, 1, 0, 3, 0, 0, 0);
      apply_stimulus("gap.s10", 8'h00, 0, 0, 3, 0, 0, 0);
      apply_stimulus("gap.s11", 8'h00, 0, 0, 8, 1, 0, 0);
      apply_stimulus("gap.s12", 8'h00, 0, 0, 8, 0, 14, 1);
      apply_stimulus("gap.s13", 8'h00, 0, 0, 8, 0, 14, 0);

      $display("[TB] clear on final sample, then fresh window");
      apply_stimulus("clr.s0",  8'h01, 1, 0, 8, 0, 14, 0);
      apply_stimulus("clr.s1",  8'h03, 1, 0, 8, 0, 14, 0);
      apply_stimulus("clr.s2",  8'h07, 1, 0, 1, 1, 14, 0);
      apply_stimulus("clr.s3",  8'hFF, 1, 0, 2, 1, 14, 0);
      apply_stimulus("clr.s4",  8'h00, 0, 0, 3, 1, 14, 0);
      apply_stimulus("clr.s5",  8'h00, 0, 0, 8, 1, 14, 0);
      apply_stimulus("clr.s6",  8'h00, 0, 1, 8, 0, 14, 0);
      apply_stimulus("clr.s7",  8'h00, 0, 0, 8, 0, 14, 0);
      apply_stimulus("clr.s8",  8'h0F, 1, 0, 8, 0, 14, 0);
      apply_stimulus("clr.s9",  8'h0F, 1, 0, 8, 0, 14, 0);
      apply_stimulus("clr.s10", 8'h0F, 1, 0, 4, 1, 14, 0);
      apply_stimulus("clr.s11", 8'h0F, 1, 0, 4, 1, 14, 0);
      apply_stimulus("clr.s12", 8'h00, 0, 0, 4, 1, 14, 0);
      apply_stimulus("clr.s13", 8'h00, 0, 0, 4, 1, 14, 0);
      apply_stimulus("clr.s14", 8'h00, 0, 0, 4, 0, 16, 1);
      apply_stimulus("clr.s15", 8'h00, 0, 0, 4, 0, 16, 0);

      $display("[TB] reset mid-window with a vector in flight");
      apply_reset();
      apply_stimulus("mid.s0", 8'h01, 1, 0, 0, 0, 0, 0);
      apply_stimulus("mid.s1", 8'h03, 1, 0, 0, 0, 0, 0);
      apply_stimulus("mid.s2", 8'hFF, 1, 0, 1, 1, 0, 0);
      apply_stimulus("mid.s3", 8'h00, 0, 0, 2, 1, 0, 0);
      nRST = 1'b0;
      #2;
      check_output("mid.async sum",       32'(sum),       32'd0);
      check_output("mid.async sum_valid", 32'(sum_valid), 32'd0);
      check_output("mid.async acc_valid", 32'(acc_valid), 32'd0);
      #2;
      nRST = 1'b1;
      apply_stimulus("post.s0", 8'h80, 1, 0, 0, 0, 0, 0);
      apply_stimulus("post.s1", 8'h80, 1, 0, 0, 0, 0, 0);
      apply_stimulus("post.s2", 8'h80, 1, 0, 1, 1, 0, 0);
      apply_stimulus("post.s3", 8'h80, 1, 0, 1, 1, 0, 0);
      apply_stimulus("post.s4", 8'h00, 0, 0, 1, 1, 0, 0);
      apply_stimulus("post.s5", 8'h00, 0, 0, 1, 1, 0, 0);
      apply_stimulus("post.s6", 8'h00, 0, 0, 1, 0, 4, 1);
      apply_stimulus("post.s7", 8'h00, 0, 0, 1, 0, 4, 0);

      $display("[TB] two-input, single-sample window");
      inputs2   = 2'b11;
      in_valid2 = 1'b1;
      @(posedge CLK);
      #1;
      check_output("w1.t1 sum",       32'(sum2),       32'd2);
      check_output("w1.t1 sum_valid", 32'(sum_valid2), 32'd1);
      check_output("w1.t1 acc_valid", 32'(acc_valid2), 32'd0);
      inputs2 = 2'b01;
      @(posedge CLK);
      #1;
      check_output("w1.t2 sum",       32'(sum2),       32'd1);
      check_output("w1.t2 acc",       32'(acc2),       32'd2);
      check_output("w1.t2 acc_valid", 32'(acc_valid2), 32'd1);
      in_valid2 = 1'b0;
      @(posedge CLK);
      #1;
      check_output("w1.t3 sum_valid", 32'(sum_valid2), 32'd0);
      check_output("w1.t3 acc",       32'(acc2),       32'd1);
      check_output("w1.t3 acc_valid", 32'(acc_valid2), 32'd1);
      @(posedge CLK);
      #1;
      check_output("w1.t4 acc",       32'(acc2),       32'd1);
      check_output("w1.t4 acc_valid", 32'(acc_valid2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 Parameter NUM_INPUTS, default 8: number of 1-bit inputs; power of two, >= 2.
REQ-002 Parameter WINDOW, default 16: number of valid sums per accumulation window; >= 1.
REQ-003 Derived constants: LEVELS = log2(NUM_INPUTS); SW = LEVELS+1 (sum width); AW = clog2(NUM_INPUTS*WINDOW+1) (accumulator width).
REQ-004 CLK  input  1  clock, rising edge; one clock, reset is asynchronous and active-low.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 inputs  input  NUM_INPUTS  bit-vector to be counted (one stochastic-bitstream bit per lane).
REQ-007 in_valid  input  1  inputs is valid this cycle.
REQ-008 clear  input  1  synchronous clear of accumulator and window counter.
REQ-009 sum  output  SW  population count of a valid input vector.
REQ-010 sum_valid  output  1  sum corresponds to a new valid input vector this cycle.
REQ-011 acc  output  AW  total of the last completed window.
REQ-012 acc_valid  output  1  one-cycle pulse: acc updated this cycle.

Function
REQ-013 Tree: level k (1..LEVELS) adds adjacent pairs from level k-1, producing NUM_INPUTS/2^k partial sums of width k+1; level 0 is inputs.
REQ-014 Every level output is registered; no stall/back-pressure; one vector accepted per cycle.
REQ-015 Latency: vector presented with in_valid=1 in cycle t gives sum and sum_valid=1 in cycle t+LEVELS.
REQ-016 A valid bit travels with each level; a level's data registers load only when its incoming valid is 1, else hold; sum holds last valid value while sum_valid=0.
REQ-017 Sums are exact; no overflow possible at any level (width k+1 at level k).
REQ-018 Accumulator state: running total (AW bits) and window counter (0..WINDOW-1).
REQ-019 On sum_valid=1, clear=0, counter<WINDOW-1: running += sum, counter += 1.
REQ-020 On sum_valid=1, clear=0, counter=WINDOW-1: acc <= running+sum, acc_valid=1 next cycle, running <= 0, counter <= 0.
REQ-021 acc_valid is high exactly one cycle per completed window; acc holds its value until the next completion.
REQ-022 clear=1: running <= 0, counter <= 0; a coincident sum_valid sample is discarded; no acc_valid; acc unchanged; tree pipeline unaffected.
REQ-023 WINDOW=1: every valid sum produces acc=sum and acc_valid one cycle after sum_valid.

Reset
REQ-024 nRST low asynchronously zeroes all tree registers, valid bits, running total, counter, sum, sum_valid, acc, acc_valid.
REQ-025 Reset mid-window or with vectors in flight drops all in-flight data; first sum_valid after release is for a vector accepted after release.
REQ-026 Reset deassertion is assumed synchronous to CLK at system level; no internal synchronizer.

Structure
REQ-027 Shared package adder_tree_pkg holds width helper functions (sum width for a level, accumulator width) for reuse by sibling utilities.
REQ-028 One sub-module, adder_tree_level (parametrised pair-add level with registered outputs and valid), instantiated LEVELS times via generate.
REQ-029 Accumulator/window logic lives in adder_tree_pipe top level.

Verification (NUM_INPUTS=8, WINDOW=4 unless stated)
REQ-030 Reset: hold nRST low, drive inputs=8'hFF, in_valid=1 -> sum=0, sum_valid=0, acc=0, acc_valid=0 throughout.
REQ-031 Single 8'hFF with in_valid for one cycle t -> sum=8, sum_valid=1 only in cycle t+3.
REQ-032 Back-to-back 8'h01,8'h03,8'h07,8'hFF -> sums 1,2,3,8 on consecutive cycles; acc=14, acc_valid pulse one cycle after sum=8.
REQ-033 Same four vectors with two idle cycles between each -> identical sums, sum holds during gaps, acc=14 once.
REQ-034 clear asserted in the cycle sum=8 appears -> no acc_valid, acc stays previous value; next four vectors 8'h0F x4 -> acc=16.
REQ-035 nRST pulsed after two valid sums, then four 8'h80 vectors -> acc=4 (no carry-over); NUM_INPUTS=2, WINDOW=1 build: 2'b11 -> sum=2 at t+1, acc=2 at t+2.
